// File: rtl/sc_transition_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// sc_transition_sequencer_pkg
// Shared definitions for the level-transition sequencer and the level/video
// blocks that decode its phase output.
//   sc_phase_e     : sequencer state encoding (also driven out on phase_OutBUS)
//   LEVEL_COUNT    : number of game levels; the level counter wraps at this
//   sc_next_level  : level + 1 modulo LEVEL_COUNT
// ---------------------------------------------------------------------------
package sc_transition_sequencer_pkg;

  localparam int LEVEL_COUNT = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BLANK  = 3'd1,
    ST_SCROLL = 3'd2,
    ST_LOAD   = 3'd3,
    ST_DONE   = 3'd4
  } sc_phase_e;

  // Widened by one bit so the increment of the top level cannot silently
  // truncate before the wrap comparison.
  function automatic logic [1:0] sc_next_level(input logic [1:0] level);
    logic [2:0] level_inc;
    level_inc = {1'b0, level} + 3'd1;
    if (int'(level_inc) >= LEVEL_COUNT) begin
      return 2'd0;
    end
    return level_inc[1:0];
  endfunction

endpackage

// File: rtl/sc_phase_timer.sv
// ---------------------------------------------------------------------------
// sc_phase_timer
// Free-standing phase timer for the transition sequencer. Counts from 0 up to
// all-ones and stops there; the owner clears it to start a new phase.
// Ports:
//   SC_PHTIMER_CLOCK_50     in   system clock, rising edge
//   SC_PHTIMER_RESET_InLow  in   asynchronous active-low reset
//   enable                  in   count up by one this edge
//   clear                   in   force count to zero (wins over enable)
//   eoc_OutLow              out  low while count is all-ones (end of count)
// ---------------------------------------------------------------------------
module sc_phase_timer #(
  parameter int COUNTER_DATAWIDTH_BUS = 27
) (
  input  logic SC_PHTIMER_CLOCK_50,
  input  logic SC_PHTIMER_RESET_InLow,
  input  logic enable,
  input  logic clear,
  output logic eoc_OutLow
);

  logic [COUNTER_DATAWIDTH_BUS-1:0] count;

  always_ff @(posedge SC_PHTIMER_CLOCK_50 or negedge SC_PHTIMER_RESET_InLow) begin
    if (!SC_PHTIMER_RESET_InLow) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign eoc_OutLow = ~(&count);

endmodule

// File: rtl/sc_transition_sequencer.sv
// ---------------------------------------------------------------------------
// sc_transition_sequencer
// Sequences a level change: blank the screen, scroll the road in, load the
// next level number, then pulse done. BLANK and SCROLL each last
// 2^COUNTER_DATAWIDTH_BUS clocks of un-paused time.
// Ports:
//   SC_TRANSEQ_CLOCK_50          in   system clock, rising edge
//   SC_TRANSEQ_RESET_InLow       in   asynchronous active-low reset
//   SC_TRANSEQ_start_InLow       in   level-transition request (level)
//   SC_TRANSEQ_pause_InLow       in   freezes timed phases while low
//   SC_TRANSEQ_level_InBUS       in   current game level
//   SC_TRANSEQ_busy_OutLow       out  low whenever not IDLE
//   SC_TRANSEQ_blank_OutLow      out  low in BLANK
//   SC_TRANSEQ_scroll_OutLow     out  low in SCROLL
//   SC_TRANSEQ_done_OutLow       out  low for the single DONE cycle
//   SC_TRANSEQ_levelnext_OutBUS  out  registered next level
//   SC_TRANSEQ_phase_OutBUS      out  current state encoding
// ---------------------------------------------------------------------------
module sc_transition_sequencer
  import sc_transition_sequencer_pkg::*;
#(
  parameter int COUNTER_DATAWIDTH_BUS = 27
) (
  input  logic       SC_TRANSEQ_CLOCK_50,
  input  logic       SC_TRANSEQ_RESET_InLow,
  input  logic       SC_TRANSEQ_start_InLow,
  input  logic       SC_TRANSEQ_pause_InLow,
  input  logic [1:0] SC_TRANSEQ_level_InBUS,
  output logic       SC_TRANSEQ_busy_OutLow,
  output logic       SC_TRANSEQ_blank_OutLow,
  output logic       SC_TRANSEQ_scroll_OutLow,
  output logic       SC_TRANSEQ_done_OutLow,
  output logic [1:0] SC_TRANSEQ_levelnext_OutBUS,
  output logic [2:0] SC_TRANSEQ_phase_OutBUS
);

  sc_phase_e state;
  sc_phase_e state_next;
  logic      timed_phase;
  logic      timer_enable;
  logic      timer_clear;
  logic      timer_eoc_OutLow;
  logic      timer_eoc;
  logic      phase_exit;
  logic [1:0] level_next_reg;

  assign timed_phase = (state == ST_BLANK) || (state == ST_SCROLL);
  assign timer_eoc   = ~timer_eoc_OutLow;

  // Pause wins over end-of-count: the phase only exits on an edge where the
  // timer is saturated and pause is released, so a paused timer sits at
  // all-ones with eoc still active.
  assign phase_exit   = timed_phase && timer_eoc && SC_TRANSEQ_pause_InLow;
  assign timer_enable = timed_phase && SC_TRANSEQ_pause_InLow && !timer_eoc;
  assign timer_clear  = !timed_phase || phase_exit;

  sc_phase_timer #(
    .COUNTER_DATAWIDTH_BUS(COUNTER_DATAWIDTH_BUS)
  ) u_phase_timer (
    .SC_PHTIMER_CLOCK_50   (SC_TRANSEQ_CLOCK_50),
    .SC_PHTIMER_RESET_InLow(SC_TRANSEQ_RESET_InLow),
    .enable                (timer_enable),
    .clear                 (timer_clear),
    .eoc_OutLow            (timer_eoc_OutLow)
  );

  always_ff @(posedge SC_TRANSEQ_CLOCK_50 or negedge SC_TRANSEQ_RESET_InLow) begin
    if (!SC_TRANSEQ_RESET_InLow) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Start is level-sensitive: a request still held low when DONE returns to
  // IDLE launches another transition one cycle later.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (!SC_TRANSEQ_start_InLow) begin
          state_next = ST_BLANK;
        end
      end
      ST_BLANK: begin
        if (phase_exit) begin
          state_next = ST_SCROLL;
        end
      end
      ST_SCROLL: begin
        if (phase_exit) begin
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge SC_TRANSEQ_CLOCK_50 or negedge SC_TRANSEQ_RESET_InLow) begin
    if (!SC_TRANSEQ_RESET_InLow) begin
      level_next_reg <= 2'd0;
    end else if (state == ST_LOAD) begin
      level_next_reg <= sc_next_level(SC_TRANSEQ_level_InBUS);
    end
  end

  assign SC_TRANSEQ_busy_OutLow      = (state == ST_IDLE);
  assign SC_TRANSEQ_blank_OutLow     = (state != ST_BLANK);
  assign SC_TRANSEQ_scroll_OutLow    = (state != ST_SCROLL);
  assign SC_TRANSEQ_done_OutLow      = (state != ST_DONE);
  assign SC_TRANSEQ_levelnext_OutBUS = level_next_reg;
  assign SC_TRANSEQ_phase_OutBUS     = state;

endmodule

// File: tb/tb_sc_transition_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sc_transition_sequencer
// Self-checking bench for sc_transition_sequencer with a 4-bit phase timer
// (16-cycle phases). A phase-level reference model tracks which phase the
// sequencer is in and how many un-paused cycles of it have elapsed.
// ---------------------------------------------------------------------------
module tb_sc_transition_sequencer;

  localparam int W         = 4;
  localparam int PHASE_LEN = 1 << W;

  localparam int P_IDLE   = 0;
  localparam int P_BLANK  = 1;
  localparam int P_SCROLL = 2;
  localparam int P_LOAD   = 3;
  localparam int P_DONE   = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_n;
  logic       pause_n;
  logic [1:0] level;
  logic       busy_n;
  logic       blank_n;
  logic       scroll_n;
  logic       done_n;
  logic [1:0] level_next;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;

  int m_phase;
  int m_progress;
  int m_level_next;

  typedef struct {
    logic       start_n;
    logic       pause_n;
    logic [1:0] level;
    int         cycles;
    int         exp_phase;
    int         exp_level_next;
    string      name;
  } vec_t;

  vec_t vecs[$];

  always #10 clk = ~clk;

  sc_transition_sequencer #(
    .COUNTER_DATAWIDTH_BUS(W)
  ) dut (
    .SC_TRANSEQ_CLOCK_50        (clk),
    .SC_TRANSEQ_RESET_InLow     (rst_n),
    .SC_TRANSEQ_start_InLow     (start_n),
    .SC_TRANSEQ_pause_InLow     (pause_n),
    .SC_TRANSEQ_level_InBUS     (level),
    .SC_TRANSEQ_busy_OutLow     (busy_n),
    .SC_TRANSEQ_blank_OutLow    (blank_n),
    .SC_TRANSEQ_scroll_OutLow   (scroll_n),
    .SC_TRANSEQ_done_OutLow     (done_n),
    .SC_TRANSEQ_levelnext_OutBUS(level_next),
    .SC_TRANSEQ_phase_OutBUS    (phase)
  );

  task automatic checkValue(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_phase      = P_IDLE;
    m_progress   = 0;
    m_level_next = 0;
  endtask

  // One rising edge of the reference: timed phases need PHASE_LEN un-paused
  // cycles; pause simply stops the elapsed-cycle count.
  task automatic modelStep();
    case (m_phase)
      P_IDLE: begin
        if (!start_n) begin
          m_phase    = P_BLANK;
          m_progress = 0;
        end
      end
      P_BLANK, P_SCROLL: begin
        if (pause_n) begin
          if (m_progress == PHASE_LEN - 1) begin
            m_phase    = m_phase + 1;
            m_progress = 0;
          end else begin
            m_progress = m_progress + 1;
          end
        end
      end
      P_LOAD: begin
        m_level_next = (int'(level) + 1) % 4;
        m_phase      = P_DONE;
      end
      default: m_phase = P_IDLE;
    endcase
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".phase"},     8'(phase),      8'(m_phase));
    checkValue({tag, ".busy"},      8'(busy_n),     8'(m_phase == P_IDLE));
    checkValue({tag, ".blank"},     8'(blank_n),    8'(m_phase != P_BLANK));
    checkValue({tag, ".scroll"},    8'(scroll_n),   8'(m_phase != P_SCROLL));
    checkValue({tag, ".done"},      8'(done_n),     8'(m_phase != P_DONE));
    checkValue({tag, ".levelnext"}, 8'(level_next), 8'(m_level_next));
  endtask

  task automatic stepCycle(input string tag);
    @(posedge clk);
    if (rst_n) modelStep();
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic applyStimulus(input vec_t v);
    start_n = v.start_n;
    pause_n = v.pause_n;
    level   = v.level;
    for (int i = 0; i < v.cycles; i++) stepCycle(v.name);
    checkValue({v.name, ".end_phase"},     8'(phase),      8'(v.exp_phase));
    checkValue({v.name, ".end_levelnext"}, 8'(level_next), 8'(v.exp_level_next));
  endtask

  function automatic vec_t mkVec(input logic s, input logic p, input logic [1:0] l, input int n,
                                 input int ph, input int ln, input string name);
    vec_t v;
    v.start_n = s; v.pause_n = p; v.level = l; v.cycles = n;
    v.exp_phase = ph; v.exp_level_next = ln; v.name = name;
    return v;
  endfunction

  initial begin
    int busy_cnt, blank_cnt, scroll_cnt, load_cnt, done_cnt, idle_cnt;

    rst_n   = 1'b0;
    start_n = 1'b0;
    pause_n = 1'b1;
    level   = 2'd1;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset");
    checkValue("reset.phase_const", 8'(phase), 8'd0);
    checkValue("reset.busy_const",  8'(busy_n), 8'd1);
    start_n = 1'b1;
    rst_n   = 1'b1;

    // Level 1 full transition, then pause ignored in IDLE.
    vecs.push_back(mkVec(1'b0, 1'b1, 2'd1, 1,  P_BLANK,  0, "l1_enter"));
    vecs.push_back(mkVec(1'b1, 1'b1, 2'd1, 15, P_BLANK,  0, "l1_blank15"));
    vecs.push_back(mkVec(1'b1, 1'b1, 2'd1, 1,  P_SCROLL, 0, "l1_scroll"));
    vecs.push_back(mkVec(1'b1, 1'b1, 2'd1, 16, P_LOAD,   0, "l1_load"));
    vecs.push_back(mkVec(1'b1, 1'b1, 2'd1, 1,  P_DONE,   2, "l1_done"));
    vecs.push_back(mkVec(1'b1, 1'b1, 2'd1, 1,  P_IDLE,   2, "l1_idle"));
    vecs.push_back(mkVec(1'b1, 1'b0, 2'd1, 3,  P_IDLE,   2, "idle_pause"));
    // Level 3 wraps to 0.
    vecs.push_back(mkVec(1'b0, 1'b1, 2'd3, 1,  P_BLANK,  2, "l3_enter"));
    vecs.push_back(mkVec(1'b1, 1'b1, 2'd3, 32, P_LOAD,   2, "l3_load"));
    vecs.push_back(mkVec(1'b1, 1'b1, 2'd3, 1,  P_DONE,   0, "l3_wrap"));
    vecs.push_back(mkVec(1'b1, 1'b1, 2'd3, 1,  P_IDLE,   0, "l3_idle"));
    // Pause 5 cycles at BLANK timer 7: BLANK lasts 21 cycles.
    vecs.push_back(mkVec(1'b0, 1'b1, 2'd0, 1,  P_BLANK,  0, "pb_enter"));
    vecs.push_back(mkVec(1'b1, 1'b1, 2'd0, 7,  P_BLANK,  0, "pb_t7"));
    vecs.push_back(mkVec(1'b1, 1'b0, 2'd0, 5,  P_BLANK,  0, "pb_hold"));
    vecs.push_back(mkVec(1'b1, 1'b1, 2'd0, 8,  P_BLANK,  0, "pb_t15"));
    vecs.push_back(mkVec(1'b1, 1'b1, 2'd0, 1,  P_SCROLL, 0, "pb_exit"));
    // Pause lands on SCROLL timer 15: holds, then LOAD on release.
    vecs.push_back(mkVec(1'b1, 1'b1, 2'd0, 15, P_SCROLL, 0, "ps_t15"));
    vecs.push_back(mkVec(1'b1, 1'b0, 2'd0, 4,  P_SCROLL, 0, "ps_hold"));
    vecs.push_back(mkVec(1'b1, 1'b1, 2'd0, 1,  P_LOAD,   0, "ps_release"));
    vecs.push_back(mkVec(1'b1, 1'b0, 2'd0, 1,  P_DONE,   1, "ps_load_pause"));
    vecs.push_back(mkVec(1'b1, 1'b0, 2'd0, 1,  P_IDLE,   1, "ps_done_pause"));

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Full-length timing of one level-1 transition.
    busy_cnt = 0; blank_cnt = 0; scroll_cnt = 0; load_cnt = 0; done_cnt = 0;
    start_n = 1'b0; level = 2'd1; pause_n = 1'b1;
    stepCycle("len");
    start_n = 1'b1;
    for (int i = 0; i < 100 && busy_n == 1'b0; i++) begin
      busy_cnt++;
      if (!blank_n)  blank_cnt++;
      if (!scroll_n) scroll_cnt++;
      if (!done_n)   done_cnt++;
      if (phase == 3'd3) load_cnt++;
      stepCycle("len");
    end
    checkValue("len.busy_cycles",   8'(busy_cnt),   8'd34);
    checkValue("len.blank_cycles",  8'(blank_cnt),  8'd16);
    checkValue("len.scroll_cycles", 8'(scroll_cnt), 8'd16);
    checkValue("len.load_cycles",   8'(load_cnt),   8'd1);
    checkValue("len.done_cycles",   8'(done_cnt),   8'd1);
    checkValue("len.levelnext",     8'(level_next), 8'd2);

    // Start held low: back-to-back transitions with one IDLE cycle between.
    done_cnt = 0; idle_cnt = 0;
    start_n = 1'b0; level = 2'd2;
    for (int i = 0; i < 80; i++) begin
      stepCycle("held");
      if (!done_n) done_cnt++;
      if (busy_n)  idle_cnt++;
    end
    checkValue("held.done_pulses", 8'(done_cnt), 8'd2);
    checkValue("held.idle_cycles", 8'(idle_cnt), 8'd2);
    checkValue("held.rearmed",     8'(phase),    8'(P_BLANK));
    start_n = 1'b1;
    for (int i = 0; i < 100 && phase != 3'd0; i++) stepCycle("drain");
    checkValue("drain.idle", 8'(phase), 8'd0);

    // Reset in SCROLL at timer 9 aborts the transition.
    start_n = 1'b0; level = 2'd2;
    stepCycle("abort");
    start_n = 1'b1;
    repeat (25) stepCycle("abort");
    checkValue("abort.in_scroll", 8'(phase), 8'(P_SCROLL));
    #3;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkValue("abort.phase",     8'(phase),      8'd0);
    checkValue("abort.busy",      8'(busy_n),     8'd1);
    checkValue("abort.blank",     8'(blank_n),    8'd1);
    checkValue("abort.scroll",    8'(scroll_n),   8'd1);
    checkValue("abort.done",      8'(done_n),     8'd1);
    checkValue("abort.levelnext", 8'(level_next), 8'd0);
    repeat (3) stepCycle("abort_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      stepCycle("abort_after");
      if (!done_n) checkValue("abort.no_done", 8'(done_n), 8'd1);
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 2000; i++) begin
      start_n = ($urandom_range(0, 7) != 0);
      pause_n = ($urandom_range(0, 3) != 0);
      level   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("rand_rst");
        stepCycle("rand_rst");
        rst_n = 1'b1;
      end else begin
        stepCycle("rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
